// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one sequential signed Booth multiplier core
// among NUM_REQ requesters, with a watchdog on the core's done pulse.
//
// Handshakes: req_ready[g] is a one-cycle accept pulse raised only in IDLE, and only while
// req_valid[g] is high. rsp_valid stays high, with id/product/err frozen, until the
// cycle rsp_ready is sampled high. mul_start is a one-cycle strobe. mul_done counts only
// while the core is being waited on.
module booth_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_m,
    input  logic [NUM_REQ*WIDTH-1:0]     req_q,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]           rsp_product,
    output logic                         rsp_err,
    output logic                         mul_start,
    output logic [WIDTH-1:0]             mul_m,
    output logic [WIDTH-1:0]             mul_q,
    input  logic                         mul_done,
    input  logic [2*WIDTH-1:0]           mul_product,
    output logic [1:0]                   dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDW-1:0]       r_rr_ptr;
    logic [WDW-1:0]       r_wd_cnt;
    logic [WDW-1:0]       w_wd_inc;
    logic                 w_timeout;
    logic [IDW-1:0]       r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_product;
    logic                 r_rsp_err;
    logic [WIDTH-1:0]     r_mul_m;
    logic [WIDTH-1:0]     r_mul_q;
    logic                 w_any;
    logic [IDW-1:0]       w_gnt;
    logic [IDW-1:0]       w_idx;
    logic [WIDTH-1:0]     w_sel_m;
    logic [WIDTH-1:0]     w_sel_q;

    // Cyclic scan starting at r_rr_ptr; the first valid requester found wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_m = '0;
        w_sel_q = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt == IDW'(j)) begin
                w_sel_m = req_m[j*WIDTH +: WIDTH];
                w_sel_q = req_q[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // The watchdog compares the post-increment count, so the abort lands
    // exactly TIMEOUT cycles after the start pulse.
    assign w_wd_inc  = r_wd_cnt + 1'b1;
    assign w_timeout = (w_wd_inc == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mul_done || w_timeout) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr      <= '0;
            r_wd_cnt      <= '0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_mul_m       <= '0;
            r_mul_q       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_mul_m  <= w_sel_m;
                        r_mul_q  <= w_sel_q;
                        r_rsp_id <= w_gnt;
                    end
                end
                S_ISSUE: r_wd_cnt <= '0;
                S_WAIT: begin
                    r_wd_cnt <= w_wd_inc;
                    if (mul_done) begin
                        r_rsp_product <= mul_product;
                        r_rsp_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= (r_rsp_id == IDW'(NUM_REQ - 1)) ? '0 : r_rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_start   = (r_state == S_ISSUE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
    assign rsp_err     = r_rsp_err;
    assign mul_m       = r_mul_m;
    assign mul_q       = r_mul_q;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: a fake core, queued requesters, a transaction-level
// reference model compared every cycle, and directed vectors with literal products.
module tb_booth_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_m = '0;
    logic [N*W-1:0]   req_q = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             rsp_err;
    logic             mul_start;
    logic [W-1:0]     mul_m;
    logic [W-1:0]     mul_q;
    logic             mul_done = 1'b0;
    logic [2*W-1:0]   mul_product = '0;
    logic [1:0]       dbg_state;

    booth_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_m(req_m), .req_q(req_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_done(mul_done), .mul_product(mul_product),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requesters ----------------
    logic [W-1:0] rq_m[N][$];
    logic [W-1:0] rq_q[N][$];

    task automatic post(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
        rq_m[i].push_back(m);
        rq_q[i].push_back(q);
    endtask

    always begin : drv
        logic [N-1:0] seen;
        @(posedge clk);
        seen = req_ready;
        #1;
        for (int i = 0; i < N; i++) begin
            if (seen[i] && rq_m[i].size() > 0) begin
                void'(rq_m[i].pop_front());
                void'(rq_q[i].pop_front());
            end
            req_valid[i] = (rq_m[i].size() > 0);
            if (rq_m[i].size() > 0) begin
                req_m[i*W +: W] = rq_m[i][0];
                req_q[i*W +: W] = rq_q[i][0];
            end
        end
    end

    // ---------------- fake multiplier core ----------------
    int core_lat   = 3;   // done arrives core_lat cycles after start; 0 = never
    int core_cnt   = 0;
    int inject_cyc = -1;

    always begin : core
        logic st;
        logic signed [31:0] p;
        @(posedge clk);
        st = mul_start;
        #1;
        if (!rst) begin
            core_cnt = 0;
            mul_done = 1'b0;
        end else begin
            if (st) core_cnt = core_lat;
            else if (core_cnt > 0) core_cnt--;
            if (cyc == inject_cyc) begin
                mul_done    = 1'b1;
                mul_product = 32'hDEADBEEF;
            end else if (core_cnt == 1) begin
                p           = $signed(mul_m) * $signed(mul_q);
                mul_done    = 1'b1;
                mul_product = p;
            end else begin
                mul_done    = 1'b0;
                mul_product = $urandom;
            end
        end
    end

    // ---------------- reference model ----------------
    logic        m_busy = 1'b0;
    logic        m_resp = 1'b0;
    int          m_age  = 0;
    int          m_ptr  = 0;
    int          m_id   = 0;
    logic [W-1:0] m_opm = '0;
    logic [W-1:0] m_opq = '0;
    logic [31:0] m_prod = '0;
    logic        m_err  = 1'b0;
    logic [31:0] exp_q[$];

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[2'((ptr + k) % N)]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin : mdl
        int g;
        int a;
        int b;
        if (!rst) begin
            m_busy = 1'b0; m_resp = 1'b0; m_age = 0; m_ptr = 0;
            m_opm = '0; m_opq = '0;
            exp_q.delete();
        end else if (!m_busy) begin
            g = rr_pick(m_ptr, req_valid);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_id   = g;
                m_opm  = req_m[g*W +: W];
                m_opq  = req_q[g*W +: W];
                a = $signed(m_opm);
                b = $signed(m_opq);
                exp_q.push_back(32'(a * b));
            end
        end else if (!m_resp) begin
            if (m_age >= 2 && mul_done) begin
                m_resp = 1'b1; m_err = 1'b0; m_prod = exp_q.pop_front();
            end else if (m_age == TO) begin
                m_resp = 1'b1; m_err = 1'b1; m_prod = '0;
                void'(exp_q.pop_front());
            end else begin
                m_age++;
            end
        end else if (rsp_ready) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_ptr  = (m_id + 1) % N;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic [N-1:0] er;
        int g;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_product", rsp_product, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_mul_m", mul_m, 0);
            chk("rst_mul_q", mul_q, 0);
        end else begin
            er = '0;
            if (!m_busy) begin
                g = rr_pick(m_ptr, req_valid);
                if (g >= 0) er[2'(g)] = 1'b1;
            end
            chk("req_ready", req_ready, er);
            chk("mul_start", mul_start, (m_busy && !m_resp && m_age == 1));
            chk("rsp_valid", rsp_valid, m_resp);
            chk("mul_m", mul_m, m_opm);
            chk("mul_q", mul_q, m_opq);
            if (m_resp) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_product", rsp_product, m_prod);
                chk("rsp_err", rsp_err, m_err);
            end
        end
    end

    // ---------------- directed tasks ----------------
    task automatic wait_rsp(input int exp_id, input logic [31:0] exp_prod, input logic exp_err,
                            input int hold, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, exp_id);
        chk({tag, "_product"}, rsp_product, exp_prod);
        chk({tag, "_err"}, rsp_err, exp_err);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    logic [31:0] rr_prod[8] = '{32'd7, 32'd14, 32'd21, 32'd28, 32'd7, 32'd14, 32'd21, 32'd28};

    initial begin : main
        int n;
        int s;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // single request and signed corners
        post(0, 16'd18, 16'd999);
        wait_rsp(0, 32'h0000463E, 1'b0, 0, "t1");
        post(2, 16'hF6F9, 16'd11111);
        wait_rsp(2, 32'hFE78312F, 1'b0, 0, "t2_neg");
        post(1, 16'hFFFF, 16'hFFFF);
        wait_rsp(1, 32'h00000001, 1'b0, 0, "t2_m1");
        post(1, 16'h8000, 16'h8000);
        wait_rsp(1, 32'h40000000, 1'b0, 0, "t2_min");

        // round robin, all requesters valid from reset
        do_reset();
        for (int i = 0; i < 8; i++) post(i % N, 16'((i % N) + 1), 16'd7);
        for (int i = 0; i < 8; i++) wait_rsp(i % N, rr_prod[i], 1'b0, 0, "t3_all");
        do_reset();
        post(1, 16'd5, 16'hFFFD);
        post(3, 16'hFFFC, 16'hFFFC);
        post(1, 16'd100, 16'd200);
        wait_rsp(1, 32'hFFFFFFF1, 1'b0, 0, "t3_a");
        wait_rsp(3, 32'h00000010, 1'b0, 0, "t3_b");
        wait_rsp(1, 32'h00004E20, 1'b0, 0, "t3_c");

        // watchdog
        core_lat = 0;
        post(0, 16'd3, 16'd4);
        n = 0;
        @(negedge clk);
        while (!mul_start && n < 50) begin @(negedge clk); n++; end
        chk("t4_start_seen", mul_start, 1);
        s = cyc;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk("t4_latency", 32'(cyc - s), 32'd64);
        wait_rsp(0, 32'h0, 1'b1, 0, "t4_to");
        core_lat = 63;
        post(1, 16'd2, 16'd3);
        wait_rsp(1, 32'h6, 1'b0, 0, "t4_edge_done");
        core_lat = 64;
        post(2, 16'd2, 16'd3);
        wait_rsp(2, 32'h0, 1'b1, 0, "t4_edge_late");
        core_lat = 2;
        post(3, 16'd7, 16'hFFFA);
        wait_rsp(3, 32'hFFFFFFD6, 1'b0, 0, "t4_after");

        // backpressure with a stray done during RESP
        core_lat = 3;
        post(0, 16'hFFFF, 16'd5);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        post(2, 16'd9, 16'd9);
        inject_cyc = cyc + 3;
        wait_rsp(0, 32'hFFFFFFFB, 1'b0, 10, "t5_hold");
        inject_cyc = -1;
        wait_rsp(2, 32'h00000051, 1'b0, 0, "t5_next");

        // reset in the middle of WAIT
        core_lat = 0;
        post(2, 16'd5, 16'd5);
        n = 0;
        @(negedge clk);
        while (!mul_start && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_mul_m", mul_m, 0);
        chk("t6_mul_q", mul_q, 0);
        chk("t6_rsp_id", rsp_id, 0);
        chk("t6_mul_start", mul_start, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        core_lat = 3;
        post(1, 16'd6, 16'd7);
        post(3, 16'd8, 16'd9);
        wait_rsp(1, 32'h0000002A, 1'b0, 0, "t6_first");
        wait_rsp(3, 32'h00000048, 1'b0, 0, "t6_second");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
